// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

    localparam int          FETCH_ADDR_W = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [31:0]             instr;
    } fetch_entry_t;

    // ST_DROP: a redirect orphaned an in-flight request whose ack must be swallowed
    typedef enum logic {
        ST_FETCH,
        ST_DROP
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs ahead of IF/ID.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush beats push; DEPTH is a power of two so pointers wrap naturally
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= push_data;
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, talks to variable-latency imem,
// and feeds IF/ID one {pc, instr} pair per cycle through a prefetch queue.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                INC_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + 32;

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
    logic [ADDR_W-1:0] drop_addr, drop_addr_next;
    logic [CNT_W-1:0]  count;
    logic              head_valid;
    logic [ENTRY_W-1:0] head_data;
    logic              xfer;
    logic              push;
    logic              pop;

    // Only the low INC_BITS advance; upper bits stay fixed like the CPU's next-address rule
    function automatic logic [ADDR_W-1:0] inc_pc(input logic [ADDR_W-1:0] pc);
        inc_pc = {pc[ADDR_W-1:INC_BITS], pc[INC_BITS-1:0] + INC_BITS'(PC_STEP)};
    endfunction

    assign imem_req  = !rst && ((state == ST_DROP) || (count < CNT_W'(DEPTH)));
    assign imem_addr = rst ? RESET_PC : ((state == ST_DROP) ? drop_addr : fetch_pc);
    assign xfer      = imem_req && imem_ack;

    assign push = xfer && (state == ST_FETCH) && !redirect_valid;
    assign pop  = id_valid && !stall && !redirect_valid;

    assign id_valid = !rst && head_valid;
    assign id_pc    = id_valid ? head_data[ENTRY_W-1:32] : '0;
    assign id_instr = id_valid ? head_data[31:0] : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            drop_addr <= drop_addr_next;
        end
    end

    // Redirect outranks everything but reset; a request left hanging by it
    // keeps its old address until the orphaned ack arrives and is thrown away.
    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        drop_addr_next = drop_addr;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & ~ADDR_W'(3);
            if (state == ST_FETCH) begin
                if (imem_req && !imem_ack) begin
                    state_next     = ST_DROP;
                    drop_addr_next = fetch_pc;
                end
            end else if (xfer) begin
                state_next = ST_FETCH;
            end
        end else if (state == ST_DROP) begin
            if (xfer) state_next = ST_FETCH;
        end else if (xfer) begin
            fetch_pc_next = inc_pc(fetch_pc);
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  ({fetch_pc, imem_rdata}),
        .pop        (pop),
        .count      (count),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory model plus an id_* scoreboard,
// with a second instance dedicated to the PC low-bit wrap.
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] WRAP_PC = 32'h1234_56F8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_ack, id_valid;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;

    logic        stall_w = 1'b0;
    logic        redirect_valid_w = 1'b0;
    logic [31:0] redirect_pc_w = '0;
    logic        imem_req_w, imem_ack_w, id_valid_w;
    logic [31:0] imem_addr_w, imem_rdata_w, id_instr_w, id_pc_w;

    int passes = 0;
    int checks = 0;
    int fails  = 0;
    int latency = 0;
    int wait_cnt = 0;
    logic force_ack = 1'b0;
    logic found;
    fetch_entry_t sb[$];
    fetch_entry_t exp_e;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
    );

    if_fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .id_valid(id_valid_w), .id_instr(id_instr_w), .id_pc(id_pc_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0001;
    endfunction

    // Memory answers after `latency` wait cycles; force_ack injects a stray ack
    assign imem_ack     = force_ack || (imem_req && (wait_cnt >= latency));
    assign imem_rdata   = instr_of(imem_addr);
    assign imem_ack_w   = imem_req_w;
    assign imem_rdata_w = instr_of(imem_addr_w);

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic st, input logic rv,
                                 input logic [31:0] rpc);
        rst            = r;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic pushStream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            fetch_entry_t e;
            e.pc    = start + 32'(4 * i);
            e.instr = instr_of(e.pc);
            sb.push_back(e);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_req"},      64'(imem_req), 64'd0);
        checkOutput({tag, "_addr"},     64'(imem_addr), 64'd0);
        checkOutput({tag, "_id_valid"}, 64'(id_valid), 64'd0);
        checkOutput({tag, "_id_instr"}, 64'(id_instr), 64'd0);
        checkOutput({tag, "_id_pc"},    64'(id_pc), 64'd0);
    endtask

    // Every instruction IF/ID accepts must be the next one the bench expects
    always @(negedge clk) begin
        if (!rst && id_valid && !stall && !redirect_valid) begin
            if (sb.size() == 0) begin
                checkOutput("extra_id", 64'(id_pc), 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                exp_e = sb.pop_front();
                checkOutput("sb_id_pc", 64'(id_pc), 64'(exp_e.pc));
                checkOutput("sb_id_instr", 64'(id_instr), 64'(exp_e.instr));
            end
        end else if (!rst && !id_valid) begin
            checkOutput("idle_id_instr", 64'(id_instr), 64'(NOP_INSTR));
            checkOutput("idle_id_pc", 64'(id_pc), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advance(); settle();
        checkReset("rst");
        checkOutput("wrap_rst_addr", 64'(imem_addr_w), 64'(WRAP_PC));
        checkOutput("wrap_rst_req", 64'(imem_req_w), 64'd0);
        advance();

        // Zero-wait stream from RESET_PC
        advance(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0); pushStream(32'h0, 32); settle();
        checkOutput("c0_req", 64'(imem_req), 64'd1);
        checkOutput("c0_addr", 64'(imem_addr), 64'h0);
        checkOutput("c0_id_valid", 64'(id_valid), 64'd0);
        checkOutput("wrap_c0_addr", 64'(imem_addr_w), 64'h1234_56F8);
        advance(); settle();
        checkOutput("c1_addr", 64'(imem_addr), 64'h4);
        checkOutput("c1_id_valid", 64'(id_valid), 64'd1);
        checkOutput("wrap_c1_addr", 64'(imem_addr_w), 64'h1234_56FC);
        checkOutput("wrap_c1_id_valid", 64'(id_valid_w), 64'd1);
        checkOutput("wrap_c1_id_pc", 64'(id_pc_w), 64'(WRAP_PC));
        checkOutput("wrap_c1_id_instr", 64'(id_instr_w), 64'(instr_of(WRAP_PC)));
        advance(); settle();
        checkOutput("c2_addr", 64'(imem_addr), 64'h8);
        checkOutput("wrap_c2_addr", 64'(imem_addr_w), 64'h1234_5600);

        // Stall with id_pc=0x08: queue fills, request drops, outputs held
        advance(); stall = 1'b1; settle();
        checkOutput("c3_id_pc", 64'(id_pc), 64'h8);
        checkOutput("c3_addr", 64'(imem_addr), 64'hC);
        checkOutput("wrap_c3_addr", 64'(imem_addr_w), 64'h1234_5604);
        for (int k = 4; k <= 7; k++) begin
            advance(); settle();
            checkOutput("stall_id_pc", 64'(id_pc), 64'h8);
            checkOutput("stall_id_instr", 64'(id_instr), 64'(instr_of(32'h8)));
            checkOutput("stall_req", 64'(imem_req), 64'd0);
        end
        advance(); stall = 1'b0; settle();
        checkOutput("c8_id_pc", 64'(id_pc), 64'h8);
        checkOutput("c8_req", 64'(imem_req), 64'd0);
        advance(); settle();
        checkOutput("c9_id_pc", 64'(id_pc), 64'hC);
        checkOutput("c9_addr", 64'(imem_addr), 64'h10);
        advance(); settle();
        checkOutput("c10_id_pc", 64'(id_pc), 64'h10);
        checkOutput("c10_addr", 64'(imem_addr), 64'h14);

        // Reset with a request outstanding and a stray ack during reset
        advance(); latency = 3; settle();
        checkOutput("c11_addr", 64'(imem_addr), 64'h18);
        advance(); rst = 1'b1; force_ack = 1'b1; settle();
        checkReset("midrst");
        advance(); rst = 1'b0; force_ack = 1'b0; sb.delete(); pushStream(32'h0, 4); settle();
        checkOutput("postrst_req", 64'(imem_req), 64'd1);
        checkOutput("postrst_addr", 64'(imem_addr), 64'h0);
        checkOutput("postrst_id_valid", 64'(id_valid), 64'd0);

        // Slow memory: redirect to 0x40 while the 0x10 fetch is in flight
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            advance(); settle();
            if (imem_req && imem_addr == 32'h10) found = 1'b1;
        end
        checkOutput("reach_0x10", 64'(found), 64'd1);
        advance(); applyStimulus(1'b0, 1'b0, 1'b1, 32'h43); settle();
        checkOutput("redir_addr", 64'(imem_addr), 64'h10);
        advance(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0); sb.delete(); pushStream(32'h40, 16); settle();
        checkOutput("drop1_id_valid", 64'(id_valid), 64'd0);
        checkOutput("drop1_req", 64'(imem_req), 64'd1);
        checkOutput("drop1_addr", 64'(imem_addr), 64'h10);
        advance(); settle();
        checkOutput("drop2_addr", 64'(imem_addr), 64'h10);
        checkOutput("drop2_id_valid", 64'(id_valid), 64'd0);
        advance(); settle();
        checkOutput("resume_addr", 64'(imem_addr), 64'h40);
        checkOutput("resume_req", 64'(imem_req), 64'd1);
        checkOutput("resume_id_valid", 64'(id_valid), 64'd0);
        repeat (12) begin advance(); settle(); end

        // Redirect together with stall while the queue is full
        advance(); latency = 0; stall = 1'b1; settle();
        repeat (4) begin advance(); settle(); end
        checkOutput("full_req", 64'(imem_req), 64'd0);
        checkOutput("full_id_valid", 64'(id_valid), 64'd1);
        advance(); applyStimulus(1'b0, 1'b1, 1'b1, 32'h80); settle();
        checkOutput("rs_req", 64'(imem_req), 64'd0);
        advance(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0); sb.delete(); pushStream(32'h80, 16); settle();
        checkOutput("rs_id_valid", 64'(id_valid), 64'd0);
        checkOutput("rs_resume_req", 64'(imem_req), 64'd1);
        checkOutput("rs_resume_addr", 64'(imem_addr), 64'h80);
        advance(); settle();
        checkOutput("rs_first_id_pc", 64'(id_pc), 64'h80);
        checkOutput("rs_next_addr", 64'(imem_addr), 64'h84);
        repeat (4) begin advance(); settle(); end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage R/lw/sw pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and a request/acknowledge handshake to a variable-latency instruction memory.
- Holds fetched words in a small prefetch queue and presents one {pc, instruction} pair per cycle to IF/ID.
- Honours the hazard-unit stall and a redirect port reserved for future branch/jump support.

Parameters:
- ADDR_W, 32, PC / instruction-address width.
- DEPTH, 2, prefetch queue entries (power of 2, ≥2).
- RESET_PC, 32'h0000_0000, fetch address after reset.
- INC_BITS, 8, low PC bits that increment; upper bits are held constant.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; hold current id_* outputs, no pop.
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  instruction word valid this cycle.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  id_instr/id_pc hold a real instruction.
- id_instr  out  32  instruction to IF/ID; 32'h0 (NOP) when id_valid=0.
- id_pc  out  ADDR_W  address of id_instr; 0 when id_valid=0.

Behaviour:
- Reset: the interface is clk plus synchronous active-high rst; reset is sampled on the clk rising edge only. While rst=1, all state is cleared:
  - fetch_pc=RESET_PC, queue count=0, drop flag=0.
  - imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
- Reset mid-operation: any outstanding request is abandoned. An imem_ack received while imem_req=0 is ignored.
- PC increment: next = {fetch_pc[ADDR_W-1:INC_BITS], fetch_pc[INC_BITS-1:0] + 4}.
  - Arithmetic is modulo 2^INC_BITS, so 0x0000_00FC → 0x0000_0000 and 0x1234_56FC → 0x1234_5600.
  - This matches the CPU's existing next-address rule.
- Request rule: imem_req = !rst && (count < DEPTH). imem_addr = fetch_pc.
- Handshake:
  - A transfer completes on a cycle with imem_req && imem_ack.
  - On that cycle, push {fetch_pc, imem_rdata} into the queue and advance fetch_pc.
  - Request/address may change only on the cycle after a transfer completes.
- Push with count==DEPTH cannot occur, because req is low when the queue is full. An ack without req is ignored.
- Output: id_* are driven combinationally from the queue-head register.
  - Latency from a transfer cycle to id_valid on an empty queue is 1 cycle (no bypass).
- Pop: when id_valid && !stall. A simultaneous push and pop leaves count unchanged.
- Stall: while stall=1, id_* stay bit-identical and fetching continues until the queue is full, then req drops.
- Redirect (highest priority after rst), on the cycle redirect_valid=1:
  - Queue is cleared; next cycle id_valid=0.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - An ack in the same cycle is discarded.
  - If imem_req=1 and no ack, set drop=1. While drop=1, imem_req stays asserted at the old address until ack; that ack is discarded, drop clears, and fetching resumes at the new pc on the next cycle.
- Redirect + stall in the same cycle: redirect wins; the stall has no effect on the queue.
- Redirect while drop=1: update fetch_pc; drop stays 1.
- Queue pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Decomposition:
- Shared package if_pkg contains:
  - NOP_INSTR = 32'h0000_0000.
  - PC_STEP = 4.
  - fetch_entry_t = struct {pc[ADDR_W], instr[32]}.
- One sub-module is natural: fetch_queue.
  - Synchronous DEPTH-entry FIFO with push, pop, flush, count, head output.
  - Flush takes priority over push.
  - Wraps pointers modulo DEPTH.

Test Plan:
- Zero-wait memory (ack same cycle as req), no stall, rst released at cycle 0 → imem_addr 0x00, 0x04, 0x08 on consecutive cycles; id_valid from cycle 1; id_pc 0x00, 0x04, … one per cycle.
- PC wrap: RESET_PC=0x1234_56F8 → addresses 0x…56F8, 0x…56FC, 0x1234_5600; upper bits unchanged.
- stall=1 for 5 cycles with id_pc=0x08 → id_pc/id_instr are held; queue fills to 2, imem_req drops; after release, ids are 0x08, 0x0C, 0x10 with no gap or duplicate.
- 3-cycle-latency memory, redirect to 0x40 while a request for 0x10 is outstanding → the 0x10 word never appears on id_*; the next valid id_pc is 0x40; imem_addr stays 0x10 until that ack.
- Redirect and stall asserted in the same cycle with a full queue → id_valid=0 next cycle; count=0; fetch resumes at redirect_pc.
- rst asserted for 1 cycle mid-stream with a request outstanding → the next cycle shows all outputs at reset values; a late ack during reset is ignored; the first post-reset fetch is RESET_PC.
